// File: rtl/clk_monitor.sv
// rtl/clk_monitor.sv - clk_in edge strobes, period measurement, lock detection and timeout
// Lock needs LOCK_CNT consecutive rise-to-rise periods, each within TOL of the one before.
module clk_monitor #(
    parameter int CNT_W    = 16,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             clk_in,
    output logic             rise_stb,
    output logic             fall_stb,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             resetn,
    output logic             timeout
);

    localparam int               MC_W    = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   TOL_V   = (CNT_W+1)'(TOL);
    localparam logic [MC_W-1:0]  LOCK_V  = MC_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             s1;
    logic             s2;
    logic             s3;
    logic [CNT_W-1:0] cnt;
    logic [MC_W-1:0]  match_cnt;
    logic [MC_W-1:0]  match_cnt_d;
    logic [MC_W-1:0]  match_inc;
    logic             first_done;
    logic             first_done_d;
    logic             locked_q;
    logic             locked_d;
    logic             timeout_d;
    logic             load_period;
    logic [CNT_W:0]   cnt_x;
    logic [CNT_W:0]   per_x;
    logic [CNT_W:0]   diff;
    logic             is_match;

    // Extra bit keeps the absolute difference free of wrap-around.
    assign cnt_x     = {1'b0, cnt};
    assign per_x     = {1'b0, period};
    assign diff      = (cnt_x >= per_x) ? (cnt_x - per_x) : (per_x - cnt_x);
    assign is_match  = (diff <= TOL_V);
    assign match_inc = (match_cnt == LOCK_V) ? LOCK_V : match_cnt + 1'b1;

    always_comb begin
        state_d      = state_q;
        match_cnt_d  = match_cnt;
        first_done_d = first_done;
        locked_d     = locked_q;
        timeout_d    = timeout;
        load_period  = 1'b0;
        if (rise_stb) begin
            timeout_d = 1'b0;
            if (state_q == SEEK) begin
                state_d      = MEASURE;
                first_done_d = 1'b0;
                match_cnt_d  = '0;
            end else begin
                load_period = 1'b1;
                if (!first_done) begin
                    first_done_d = 1'b1;
                    match_cnt_d  = '0;
                end else if (is_match) begin
                    match_cnt_d = match_inc;
                    if (match_inc == LOCK_V) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end else begin
                    match_cnt_d = '0;
                    state_d     = MEASURE;
                    locked_d    = 1'b0;
                end
            end
        end else if ((state_q != SEEK) && (cnt == CNT_MAX)) begin
            state_d     = SEEK;
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            rise_stb     <= 1'b0;
            fall_stb     <= 1'b0;
            cnt          <= '0;
            state_q      <= SEEK;
            match_cnt    <= '0;
            first_done   <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked_q     <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            s1           <= clk_in;
            s2           <= s1;
            s3           <= s2;
            rise_stb     <= s2 & ~s3;
            fall_stb     <= ~s2 & s3;
            if (rise_stb) begin
                cnt <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
            state_q      <= state_d;
            match_cnt    <= match_cnt_d;
            first_done   <= first_done_d;
            locked_q     <= locked_d;
            timeout      <= timeout_d;
            period_valid <= load_period;
            if (load_period) begin
                period <= cnt;
            end
        end
    end

    assign locked = locked_q;
    assign resetn = locked_q;

endmodule

// File: tb/tb_clk_monitor.sv
// tb/tb_clk_monitor.sv - scoreboard bench for clk_monitor driven by random clk_in periods
module tb_clk_monitor;

    localparam int CNT_W    = 8;
    localparam int LOCK_CNT = 4;
    localparam int TOL      = 1;
    localparam int SAT      = (1 << CNT_W) - 1;
    localparam int MAXC     = 6000;

    logic             CLK    = 1'b0;
    logic             RESET  = 1'b1;
    logic             clk_in = 1'b1;
    logic             rise_stb;
    logic             fall_stb;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             resetn;
    logic             timeout;

    clk_monitor #(
        .CNT_W    (CNT_W),
        .LOCK_CNT (LOCK_CNT),
        .TOL      (TOL)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .clk_in       (clk_in),
        .rise_stb     (rise_stb),
        .fall_stb     (fall_stb),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .resetn       (resetn),
        .timeout      (timeout)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit rise;
        bit fall;
        bit pv;
        int per;
    } ev_t;

    ev_t evq[$];
    ev_t ev_m;
    bit  exp_locked  [MAXC];
    bit  exp_timeout [MAXC];
    int  exp_period  [MAXC];
    int  n_cmp  = 0;
    int  n_bad  = 0;
    bit  chk_en = 1'b0;

    // Reference model state: armed = past SEEK, ref = previous period.
    bit m_armed    = 1'b0;
    bit m_have_ref = 1'b0;
    bit m_locked   = 1'b0;
    int m_ref      = 0;
    int m_matches  = 0;
    int m_last_t   = 0;

    task automatic chk(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fill_locked(int from, bit v);
        for (int c = from; c < MAXC; c++) exp_locked[c] = v;
    endtask

    task automatic fill_timeout(int from, bit v);
        for (int c = from; c < MAXC; c++) exp_timeout[c] = v;
    endtask

    task automatic fill_period(int from, int v);
        for (int c = from; c < MAXC; c++) exp_period[c] = v;
    endtask

    // A rise strobe visible in cycle t.
    task automatic model_rise(int t);
        int  gap;
        int  cntv;
        int  dif;
        ev_t ev;
        gap  = t - m_last_t;
        cntv = (gap > SAT) ? SAT : gap;
        ev   = '{cyc: t, rise: 1'b1, fall: 1'b0, pv: 1'b0, per: 0};
        evq.push_back(ev);
        if (m_armed && gap > SAT) begin
            m_armed   = 1'b0;
            m_locked  = 1'b0;
            m_matches = 0;
        end
        if (!m_armed) begin
            m_armed    = 1'b1;
            m_have_ref = 1'b0;
        end else begin
            ev = '{cyc: t + 1, rise: 1'b0, fall: 1'b0, pv: 1'b1, per: cntv};
            evq.push_back(ev);
            dif = (cntv > m_ref) ? cntv - m_ref : m_ref - cntv;
            if (!m_have_ref) begin
                m_have_ref = 1'b1;
                m_matches  = 0;
            end else if (dif <= TOL) begin
                if (m_matches < LOCK_CNT) m_matches++;
                if (m_matches == LOCK_CNT) m_locked = 1'b1;
            end else begin
                m_matches = 0;
                m_locked  = 1'b0;
            end
            m_ref = cntv;
            fill_period(t + 1, cntv);
        end
        m_last_t = t;
        fill_locked(t + 1, m_locked);
        fill_timeout(t + 1, 1'b0);
        // Provisional: if no rise follows within SAT cycles the monitor times out.
        fill_timeout(t + SAT + 1, 1'b1);
        fill_locked(t + SAT + 1, 1'b0);
    endtask

    task automatic model_reset(int c);
        m_armed    = 1'b0;
        m_have_ref = 1'b0;
        m_locked   = 1'b0;
        m_matches  = 0;
        m_ref      = 0;
        fill_locked(c, 1'b0);
        fill_timeout(c, 1'b0);
        fill_period(c, 0);
    endtask

    task automatic idle(int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic drive(bit v);
        ev_t ev;
        if (v != clk_in) begin
            clk_in = v;
            if (v) begin
                model_rise(cyc + 3);
            end else begin
                ev = '{cyc: cyc + 3, rise: 1'b0, fall: 1'b1, pv: 1'b0, per: 0};
                evq.push_back(ev);
            end
        end
    endtask

    task automatic send(int hi, int lo);
        drive(1'b1);
        idle(hi);
        drive(1'b0);
        idle(lo);
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        model_reset(cyc + 1);
        idle(1);
        RESET = 1'b0;
        if (clk_in) model_rise(cyc + 3);
    endtask

    always @(negedge CLK) begin
        if (chk_en && cyc < MAXC) begin
            chk("locked", int'(locked), int'(exp_locked[cyc]));
            chk("resetn", int'(resetn), int'(exp_locked[cyc]));
            chk("timeout", int'(timeout), int'(exp_timeout[cyc]));
            chk("period_level", int'(period), exp_period[cyc]);
            if (rise_stb || fall_stb || period_valid) begin
                if (evq.size() == 0) begin
                    chk("unexpected_strobe_cycle", cyc, -1);
                end else begin
                    ev_m = evq.pop_front();
                    chk("strobe_cycle", cyc, ev_m.cyc);
                    chk("rise_stb", int'(rise_stb), int'(ev_m.rise));
                    chk("fall_stb", int'(fall_stb), int'(ev_m.fall));
                    chk("period_valid", int'(period_valid), int'(ev_m.pv));
                    if (ev_m.pv) chk("period_value", int'(period), ev_m.per);
                end
            end
            while (evq.size() > 0 && evq[0].cyc < cyc) begin
                ev_m = evq.pop_front();
                chk("missed_strobe_cycle", -1, ev_m.cyc);
            end
        end
    end

    initial begin
        int base;
        int p;
        int hi;
        int seq [11] = '{16, 17, 16, 15, 16, 19, 18, 19, 20, 19, 19};

        // clk_in high while reset releases: first rise arms SEEK.
        idle(3);
        RESET  = 1'b0;
        chk_en = 1'b1;
        model_rise(cyc + 3);
        idle(8);
        drive(1'b0);
        idle(8);
        for (int i = 0; i < 8; i++) send(8, 8);

        // Reset while locked, then jittered periods, one outlier, relock.
        idle(6);
        pulse_reset();
        idle(4);
        foreach (seq[i]) send(8, seq[i] - 8);

        // Frozen clk_in: timeout, then re-arm.
        idle(300);
        for (int i = 0; i < 3; i++) send(8, 8);

        // Period exactly at saturation, then one beyond it.
        send(8, 8);
        send(100, 155);
        send(100, 156);
        send(8, 8);
        send(8, 8);

        base = 16;
        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) base = int'($urandom_range(40, 8));
            p  = base + int'($urandom_range(4, 0)) - 2;
            hi = int'($urandom_range(p - 2, 2));
            send(hi, p - hi);
        end

        // clk_in high across a reset pulse produces a fresh arming rise.
        drive(1'b1);
        idle(6);
        pulse_reset();
        idle(8);
        drive(1'b0);
        idle(8);
        for (int i = 0; i < 7; i++) send(6, 6);
        idle(10);

        chk("queue_drained", evq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
